// File: rtl/vga_clock_pkg.sv
// Shared BCD field constants and helpers for the VGA clock time-of-day core.
package vga_clock_pkg;

    localparam int HR_T_W  = 2;
    localparam int MIN_T_W = 3;
    localparam int SEC_T_W = 3;
    localparam int UNIT_W  = 4;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h23;

    localparam int NUM_BTN = 3;
    localparam int BTN_SEC = 0;
    localparam int BTN_MIN = 1;
    localparam int BTN_HR  = 2;

    // Two-digit BCD increment that wraps to 00 after max; no carry out.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 24h BCD hours -> {pm, tens, units} in 12h form (00 -> 12 am, 12 -> 12 pm).
    function automatic logic [6:0] hr24_to_12(input logic [7:0] bcd);
        logic [4:0] h;
        logic [4:0] d;
        logic       is_pm;
        h     = 5'(bcd[7:4]) * 5'd10 + 5'(bcd[3:0]);
        is_pm = (h >= 5'd12);
        d     = is_pm ? h - 5'd12 : h;
        if (d == 5'd0)
            d = 5'd12;
        return {is_pm, (d >= 5'd10) ? 2'd1 : 2'd0, (d >= 5'd10) ? 4'(d - 5'd10) : d[3:0]};
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// One adjust button: 2-flop sync, debounce, rising-edge pulse and auto-repeat.
module button_conditioner #(
    parameter int DEBOUNCE_CYC = 65_536,
    parameter int REPEAT_DELAY = 15_750_000,
    parameter int REPEAT_RATE  = 3_150_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    localparam int DW   = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic          s1, s2, db, db_nxt, flip, rep_hit, repeating;
    logic [DW-1:0] cnt;
    logic [RW-1:0] rcnt;

    // The counter only runs while the synced value disagrees with the accepted state,
    // so any bounce back to the accepted value restarts the stability window.
    always_comb begin
        flip    = (s2 != db) && (cnt == DB_LAST);
        db_nxt  = flip ? s2 : db;
        rep_hit = repeating ? (rcnt == RATE_LAST) : (rcnt == DLY_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            db        <= 1'b0;
            cnt       <= '0;
            rcnt      <= '0;
            repeating <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            db <= db_nxt;
            if (s2 == db || flip)
                cnt <= '0;
            else
                cnt <= cnt + DW'(1);
            // Repeat decisions look at db_nxt so a release cancels a coincident repeat.
            if (db_nxt && !db) begin
                pulse     <= 1'b1;
                rcnt      <= '0;
                repeating <= 1'b0;
            end else if (db_nxt && db) begin
                pulse <= rep_hit;
                rcnt  <= rep_hit ? '0 : rcnt + RW'(1);
                if (rep_hit)
                    repeating <= 1'b1;
            end else begin
                pulse     <= 1'b0;
                rcnt      <= '0;
                repeating <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vga_clock_timekeeper.sv
// Time-of-day core: 1 Hz prescaler, BCD HH:MM:SS with carry, button adjust and 12h/24h display.
module vga_clock_timekeeper
    import vga_clock_pkg::*;
#(
    parameter int CLK_HZ       = 31_500_000,
    parameter int DEBOUNCE_CYC = 65_536,
    parameter int REPEAT_DELAY = 15_750_000,
    parameter int REPEAT_RATE  = 3_150_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               adj_hrs,
    input  logic               adj_min,
    input  logic               adj_sec,
    input  logic               mode_12h,
    input  logic               hold,
    output logic [HR_T_W-1:0]  hr_t,
    output logic [UNIT_W-1:0]  hr_u,
    output logic [MIN_T_W-1:0] min_t,
    output logic [UNIT_W-1:0]  min_u,
    output logic [SEC_T_W-1:0] sec_t,
    output logic [UNIT_W-1:0]  sec_u,
    output logic               pm,
    output logic               tick_1hz
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

    logic [NUM_BTN-1:0] btn, pulse;
    logic [PW-1:0]      pre;
    logic [7:0]         sec, min, hr;
    logic               term, tick_ev;
    logic [6:0]         h12;

    assign btn = {adj_hrs, adj_min, adj_sec};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_btn (
            .clk     (clk),
            .reset_n (reset_n),
            .btn     (btn[i]),
            .pulse   (pulse[i])
        );
    end

    // An adjust on the terminal cycle parks the prescaler there, deferring the tick by one cycle.
    assign term    = (pre == TERM);
    assign tick_ev = !hold && term && !(|pulse);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre      <= '0;
            sec      <= 8'h00;
            min      <= 8'h00;
            hr       <= 8'h00;
            tick_1hz <= 1'b0;
        end else begin
            if (!hold && !(term && |pulse))
                pre <= term ? '0 : pre + PW'(1);
            tick_1hz <= tick_ev;
            if (tick_ev) begin
                sec <= bcd_inc(sec, SEC_MAX);
                if (sec == SEC_MAX) begin
                    min <= bcd_inc(min, MIN_MAX);
                    if (min == MIN_MAX)
                        hr <= bcd_inc(hr, HR_MAX);
                end
            end else begin
                if (pulse[BTN_SEC]) sec <= bcd_inc(sec, SEC_MAX);
                if (pulse[BTN_MIN]) min <= bcd_inc(min, MIN_MAX);
                if (pulse[BTN_HR])  hr  <= bcd_inc(hr, HR_MAX);
            end
        end
    end

    assign h12   = hr24_to_12(hr);
    assign {pm, hr_t, hr_u} = mode_12h ? h12 : {1'b0, hr[5:4], hr[3:0]};
    assign min_t = min[6:4];
    assign min_u = min[3:0];
    assign sec_t = sec[6:4];
    assign sec_u = sec[3:0];

endmodule

// File: tb/tb_vga_clock_timekeeper.sv
// Bench for vga_clock_timekeeper: seconds-of-day reference model, per-cycle compare, directed + random stimulus.
module tb_vga_clock_timekeeper;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;
    localparam int RD     = 20;
    localparam int RR     = 5;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       adj_hrs = 1'b0, adj_min = 1'b0, adj_sec = 1'b0, mode_12h = 1'b0, hold = 1'b0;
    logic [1:0] hr_t;
    logic [3:0] hr_u, min_u, sec_u;
    logic [2:0] min_t, sec_t;
    logic       pm, tick_1hz;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    vga_clock_timekeeper #(
        .CLK_HZ (CLK_HZ), .DEBOUNCE_CYC (DEB), .REPEAT_DELAY (RD), .REPEAT_RATE (RR)
    ) dut (
        .clk (clk), .reset_n (reset_n), .adj_hrs (adj_hrs), .adj_min (adj_min),
        .adj_sec (adj_sec), .mode_12h (mode_12h), .hold (hold),
        .hr_t (hr_t), .hr_u (hr_u), .min_t (min_t), .min_u (min_u),
        .sec_t (sec_t), .sec_u (sec_u), .pm (pm), .tick_1hz (tick_1hz)
    );

    // Reference model: time as seconds-of-day, buttons as sample histories.
    int  tod = 0, pre = 0, kk = 0;
    bit  m_tick = 0;
    bit  pend [3];
    bit  db   [3];
    int  rise [3];
    bit  rh   [3][8];
    bit  sh   [3][8];

    task automatic m_reset();
        tod = 0; pre = 0; kk = 0; m_tick = 0;
        for (int b = 0; b < 3; b++) begin
            pend[b] = 0; db[b] = 0; rise[b] = 0;
            for (int j = 0; j < 8; j++) begin rh[b][j] = 0; sh[b][j] = 0; end
        end
    endtask

    task automatic m_step();
        logic [2:0] raw;
        bit any, stable, old;
        int h, m, s, t;
        raw = {adj_hrs, adj_min, adj_sec};
        any = pend[0] | pend[1] | pend[2];
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        m_tick = !hold && (pre == CLK_HZ - 1) && !any;
        if (m_tick)
            tod = (tod + 1) % 86400;
        else begin
            if (pend[0]) s = (s + 1) % 60;
            if (pend[1]) m = (m + 1) % 60;
            if (pend[2]) h = (h + 1) % 24;
            tod = h * 3600 + m * 60 + s;
        end
        if (!hold && !((pre == CLK_HZ - 1) && any))
            pre = (pre + 1) % CLK_HZ;
        for (int b = 0; b < 3; b++) begin
            rh[b][kk % 8] = raw[b];
            sh[b][kk % 8] = (kk >= 2) ? rh[b][(kk - 2) % 8] : 1'b0;
            stable = 1;
            for (int j = 0; j < DEB; j++)
                if (sh[b][(kk + 8 - j) % 8] == db[b]) stable = 0;
            old = db[b];
            if (stable) db[b] = !db[b];
            if (!old && db[b]) begin
                pend[b] = 1; rise[b] = kk;
            end else if (old && db[b]) begin
                t = kk - rise[b];
                pend[b] = (t == RD) || (t > RD && (t - RD) % RR == 0);
            end else
                pend[b] = 0;
        end
        kk++;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) m_reset();
        else          m_step();
    end

    function automatic logic [20:0] exp_disp(input int td, input bit md);
        int h, m, s, dh;
        bit p;
        h = td / 3600; m = (td / 60) % 60; s = td % 60;
        dh = h; p = 0;
        if (md) begin
            p  = (h >= 12);
            dh = (h % 12 == 0) ? 12 : h % 12;
        end
        return {2'(dh / 10), 4'(dh % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), p};
    endfunction

    function automatic logic [20:0] dut_disp();
        return {hr_t, hr_u, min_t, min_u, sec_t, sec_u, pm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            chk("disp", 32'(dut_disp()), 32'(exp_disp(tod, mode_12h)));
            chk("tick", 32'(tick_1hz), 32'(m_tick));
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input logic [2:0] mask, input int n);
        repeat (n) begin
            {adj_hrs, adj_min, adj_sec} = mask;
            step(6);
            {adj_hrs, adj_min, adj_sec} = 3'b000;
            step(8);
        end
    endtask

    int hrs_seq [5] = '{0, 11, 12, 13, 23};
    int incs    [5] = '{0, 11, 1, 1, 10};
    int disp12  [5] = '{12, 11, 12, 1, 11};
    int pm_seq  [5] = '{0, 0, 1, 1, 1};

    initial begin
        int tc, s0, snap;
        bit found;
        logic [20:0] snapd;

        // Reset state
        hold = 1'b1;
        step(3);
        chk("reset_disp", 32'(dut_disp()), 32'd0);
        chk("reset_tick", 32'(tick_1hz), 32'd0);
        reset_n = 1'b1;
        step(2);

        // 1: set 23:59:59 with all-button and two-button presses, then roll over
        press(3'b111, 23);
        press(3'b011, 36);
        chk("t1_set", 32'(dut_disp()), 32'({2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9, 1'b0}));
        hold = 1'b0;
        tc = 0;
        for (int i = 0; i < 10; i++) begin step(1); if (tick_1hz) tc++; end
        chk("t1_midnight", 32'(dut_disp()), 32'd0);
        chk("t1_tick_count", 32'(tc), 32'd1);
        hold = 1'b1;

        // 2: bouncing adj_min never accepted, then one clean hold -> +1 minute
        for (int i = 0; i < 10; i++) begin
            adj_min = 1'b1; step(2);
            adj_min = 1'b0; step(2);
        end
        adj_min = 1'b1; step(8);
        adj_min = 1'b0; step(10);
        chk("t2_min_once", 32'(dut_disp()), 32'({2'd0, 4'd0, 3'd0, 4'd1, 3'd0, 4'd0, 1'b0}));

        // 3: long adj_hrs hold -> edge plus three repeats
        adj_hrs = 1'b1; step(33);
        adj_hrs = 1'b0; step(12);
        chk("t3_repeat", 32'(dut_disp()), 32'({2'd0, 4'd4, 3'd0, 4'd1, 3'd0, 4'd0, 1'b0}));

        // 4: display mapping across hour boundaries
        reset_n = 1'b0; step(2); reset_n = 1'b1; step(1);
        for (int i = 0; i < 5; i++) begin
            press(3'b100, incs[i]);
            mode_12h = 1'b1; step(1);
            chk("t4_12h", 32'({hr_t, hr_u, pm}),
                32'({2'(disp12[i] / 10), 4'(disp12[i] % 10), 1'(pm_seq[i])}));
            mode_12h = 1'b0; step(1);
            chk("t4_24h", 32'({hr_t, hr_u, pm}),
                32'({2'(hrs_seq[i] / 10), 4'(hrs_seq[i] % 10), 1'b0}));
        end

        // 5: adj_sec pulse landing on the prescaler terminal cycle
        hold = 1'b0; step(3);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pre == 3) found = 1;
            else step(1);
        end
        chk("t5_align", 32'(found), 32'd1);
        s0 = tod % 60;
        adj_sec = 1'b1; step(7);
        chk("t5_adj_sec", 32'({sec_t, sec_u}), 32'({3'((s0 + 1) % 60 / 10), 4'((s0 + 1) % 10)}));
        chk("t5_no_tick", 32'(tick_1hz), 32'd0);
        adj_sec = 1'b0; step(1);
        chk("t5_tick_sec", 32'({sec_t, sec_u}), 32'({3'((s0 + 2) % 60 / 10), 4'((s0 + 2) % 10)}));
        chk("t5_tick", 32'(tick_1hz), 32'd1);
        snap = tod;
        tc = 0;
        for (int i = 0; i < 100; i++) begin step(1); if (tick_1hz) tc++; end
        chk("t5_ticks", 32'(tc), 32'd10);
        chk("t5_total", 32'(dut_disp()), 32'(exp_disp((snap + 10) % 86400, 1'b0)));

        // 6: hold freezes time; reset mid-repeat clears everything
        hold = 1'b1; step(1);
        snapd = exp_disp(tod, 1'b0);
        tc = 0;
        for (int i = 0; i < 50; i++) begin step(1); if (tick_1hz) tc++; end
        chk("t6_hold_ticks", 32'(tc), 32'd0);
        chk("t6_hold_static", 32'(dut_disp()), 32'(snapd));
        adj_hrs = 1'b1; step(30);
        reset_n = 1'b0; #1;
        chk("t6_async_reset", 32'(dut_disp()), 32'd0);
        step(3);
        reset_n = 1'b1;
        step(6);
        chk("t6_no_early_pulse", 32'(dut_disp()), 32'd0);
        step(1);
        chk("t6_redebounced", 32'(dut_disp()), 32'({2'd0, 4'd1, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0}));
        adj_hrs = 1'b0; step(12);

        // Random mix of buttons, hold and display mode
        for (int seg = 0; seg < 60; seg++) begin
            {adj_hrs, adj_min, adj_sec} = 3'($urandom);
            hold     = ($urandom_range(0, 3) == 0);
            mode_12h = 1'($urandom);
            step($urandom_range(1, 40));
        end
        {adj_hrs, adj_min, adj_sec} = 3'b000;
        hold = 1'b0;
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
